// File: rtl/regfile_wr_arbiter.sv
// rtl/regfile_wr_arbiter.sv - round-robin arbiter with burst lock sharing one register-file write port
module regfile_wr_arbiter #(
    parameter int NREQ = 3,
    parameter int AW   = 5,
    parameter int DW   = 32,
    localparam int IW   = (NREQ > 1) ? $clog2(NREQ) : 1,
    localparam int NREG = 1 << AW
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [NREQ-1:0]      req_lock,
    input  logic [NREQ*AW-1:0]   req_addr,
    input  logic [NREQ*DW-1:0]   req_data,
    output logic [NREQ-1:0]      req_ready,
    output logic                 rf_we,
    output logic [AW-1:0]        rf_waddr,
    output logic [DW-1:0]        rf_wdata,
    output logic [IW-1:0]        grant_id,
    output logic [NREG-1:0]      pending_mask,
    output logic                 drop_zero
);

    typedef enum logic {
        ARB  = 1'b0,
        LOCK = 1'b1
    } state_t;

    state_t          state, state_next;
    logic [IW-1:0]   rr_ptr, rr_ptr_next;
    logic [IW-1:0]   owner, owner_next;

    logic            arb_hit;
    logic [IW-1:0]   arb_idx;
    logic [NREQ-1:0] ready_raw;
    logic [IW-1:0]   acc_idx;
    logic            accept;
    logic [AW-1:0]   acc_addr;
    logic [DW-1:0]   acc_data;

    // First valid requester at or after rr_ptr, wrapping around.
    always_comb begin
        int            idx;
        logic [IW-1:0] cand;
        arb_hit = 1'b0;
        arb_idx = '0;
        idx     = 0;
        cand    = '0;
        for (int k = 0; k < NREQ; k++) begin
            idx = int'(rr_ptr) + k;
            if (idx >= NREQ) begin
                idx = idx - NREQ;
            end
            cand = IW'(idx);
            if (!arb_hit && req_valid[cand]) begin
                arb_hit = 1'b1;
                arb_idx = cand;
            end
        end
    end

    always_comb begin
        ready_raw = '0;
        acc_idx   = arb_idx;
        if (state == ARB) begin
            if (arb_hit) begin
                ready_raw[arb_idx] = 1'b1;
            end
        end else begin
            acc_idx          = owner;
            ready_raw[owner] = req_valid[owner];
        end
    end

    assign req_ready = rst ? ready_raw : '0;
    assign accept    = |(req_valid & req_ready);
    assign acc_addr  = req_addr[acc_idx*AW +: AW];
    assign acc_data  = req_data[acc_idx*DW +: DW];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= ARB;
            rr_ptr <= '0;
            owner  <= '0;
        end else begin
            state  <= state_next;
            rr_ptr <= rr_ptr_next;
            owner  <= owner_next;
        end
    end

    always_comb begin
        state_next  = state;
        rr_ptr_next = rr_ptr;
        owner_next  = owner;
        case (state)
            ARB: begin
                if (accept) begin
                    rr_ptr_next = (acc_idx == IW'(NREQ - 1)) ? '0 : acc_idx + 1'b1;
                    if (req_lock[acc_idx]) begin
                        state_next = LOCK;
                        owner_next = acc_idx;
                    end
                end
            end
            LOCK: begin
                // An idle owner that has dropped its lock releases the grant too.
                if ((accept && !req_lock[owner]) || (!req_valid[owner] && !req_lock[owner])) begin
                    state_next = ARB;
                end
            end
            default: state_next = ARB;
        endcase
    end

    // Beats to register 0 are consumed here and never reach the write port.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rf_we     <= 1'b0;
            rf_waddr  <= '0;
            rf_wdata  <= '0;
            grant_id  <= '0;
            drop_zero <= 1'b0;
        end else begin
            rf_we     <= accept && (acc_addr != '0);
            drop_zero <= accept && (acc_addr == '0);
            if (accept) begin
                grant_id <= acc_idx;
                if (acc_addr != '0) begin
                    rf_waddr <= acc_addr;
                    rf_wdata <= acc_data;
                end
            end
        end
    end

    always_comb begin
        pending_mask = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (req_valid[i]) begin
                pending_mask[req_addr[i*AW +: AW]] = 1'b1;
            end
        end
        if (rf_we) begin
            pending_mask[rf_waddr] = 1'b1;
        end
        pending_mask[0] = 1'b0;
    end

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// tb/tb_regfile_wr_arbiter.sv - directed bench for regfile_wr_arbiter
module tb_regfile_wr_arbiter;

    logic         clk;
    logic         rst;
    logic [2:0]   req_valid;
    logic [2:0]   req_lock;
    logic [14:0]  req_addr;
    logic [95:0]  req_data;
    logic [2:0]   req_ready;
    logic         rf_we;
    logic [4:0]   rf_waddr;
    logic [31:0]  rf_wdata;
    logic [1:0]   grant_id;
    logic [31:0]  pending_mask;
    logic         drop_zero;

    int checks = 0;
    int errors = 0;

    regfile_wr_arbiter #(.NREQ(3), .AW(5), .DW(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_lock     (req_lock),
        .req_addr     (req_addr),
        .req_data     (req_data),
        .req_ready    (req_ready),
        .rf_we        (rf_we),
        .rf_waddr     (rf_waddr),
        .rf_wdata     (rf_wdata),
        .grant_id     (grant_id),
        .pending_mask (pending_mask),
        .drop_zero    (drop_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic v, input logic l,
                           input logic [4:0] a, input logic [31:0] d);
        req_valid[i]       = v;
        req_lock[i]        = l;
        req_addr[i*5 +: 5] = a;
        req_data[i*32 +: 32] = d;
    endtask

    task automatic do_reset();
        tick();
        rst       = 1'b0;
        req_valid = '0;
        req_lock  = '0;
        req_addr  = '0;
        req_data  = '0;
        #1;
        rst = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        tick();
        rst = 1'b0;
        set_req(0, 1'b1, 1'b0, 5'd1, 32'h1000_0001);
        set_req(1, 1'b1, 1'b0, 5'd2, 32'h1000_0002);
        set_req(2, 1'b1, 1'b0, 5'd3, 32'h1000_0003);
        #1;
        checks++; if (req_ready !== 3'b000) begin errors++; $display("FAIL reset_ready got %b exp 000", req_ready); end
        checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL reset_we got %b exp 0", rf_we); end
        checks++; if (rf_waddr !== 5'd0 || rf_wdata !== 32'd0 || grant_id !== 2'd0 || drop_zero !== 1'b0) begin
            errors++; $display("FAIL reset_regs got waddr=%0d wdata=%h gid=%0d dz=%b exp 0", rf_waddr, rf_wdata, grant_id, drop_zero);
        end
        tick();
        checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL reset_held_we got %b exp 0", rf_we); end
        rst = 1'b1;
        #1;
        checks++; if (req_ready !== 3'b001) begin errors++; $display("FAIL release_ready got %b exp 001", req_ready); end
        tick();
        checks++; if (rf_we !== 1'b1 || rf_waddr !== 5'd1 || grant_id !== 2'd0) begin
            errors++; $display("FAIL release_first got we=%b waddr=%0d gid=%0d exp we=1 waddr=1 gid=0", rf_we, rf_waddr, grant_id);
        end
    endtask

    task automatic test_round_robin();
        logic [31:0] dat [3];
        dat[0] = 32'hA0A0_0001;
        dat[1] = 32'hB0B0_0002;
        dat[2] = 32'hC0C0_0003;
        do_reset();
        for (int i = 0; i < 3; i++) set_req(i, 1'b1, 1'b0, 5'(i + 1), dat[i]);
        for (int k = 0; k < 6; k++) begin
            #1;
            checks++; if (req_ready !== 3'(1 << (k % 3))) begin
                errors++; $display("FAIL rr_ready beat %0d got %b exp %b", k, req_ready, 3'(1 << (k % 3)));
            end
            tick();
            checks++; if (rf_we !== 1'b1 || rf_waddr !== 5'(k % 3 + 1) || rf_wdata !== dat[k % 3] || grant_id !== 2'(k % 3)) begin
                errors++; $display("FAIL rr_out beat %0d got we=%b waddr=%0d wdata=%h gid=%0d exp waddr=%0d wdata=%h gid=%0d",
                                   k, rf_we, rf_waddr, rf_wdata, grant_id, k % 3 + 1, dat[k % 3], k % 3);
            end
        end
        req_valid = '0;
        tick();
        checks++; if (rf_we !== 1'b0 || rf_waddr !== 5'd3 || rf_wdata !== dat[2]) begin
            errors++; $display("FAIL rr_idle got we=%b waddr=%0d wdata=%h exp we=0 waddr=3 wdata=%h", rf_we, rf_waddr, rf_wdata, dat[2]);
        end
    endtask

    task automatic test_lock();
        do_reset();
        set_req(0, 1'b0, 1'b0, 5'd1, 32'h0000_0011);
        set_req(1, 1'b0, 1'b0, 5'd2, 32'h0000_0022);
        for (int b = 0; b < 4; b++) begin
            set_req(2, 1'b1, (b < 3), 5'(8 + b), 32'h2200_0000 + 32'(b));
            if (b > 0) begin
                req_valid[0] = 1'b1;
                req_valid[1] = 1'b1;
            end
            #1;
            checks++; if (req_ready !== 3'b100) begin errors++; $display("FAIL lock_ready beat %0d got %b exp 100", b, req_ready); end
            tick();
            checks++; if (rf_we !== 1'b1 || rf_waddr !== 5'(8 + b) || grant_id !== 2'd2) begin
                errors++; $display("FAIL lock_out beat %0d got we=%b waddr=%0d gid=%0d exp waddr=%0d gid=2", b, rf_we, rf_waddr, grant_id, 8 + b);
            end
            if (b == 1) begin
                // Owner idle but still locking: nobody else may be granted.
                req_valid[2] = 1'b0;
                #1;
                checks++; if (req_ready !== 3'b000) begin errors++; $display("FAIL lock_idle_ready got %b exp 000", req_ready); end
                tick();
                checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL lock_idle_we got %b exp 0", rf_we); end
            end
        end
        req_valid[2] = 1'b0;
        req_lock[2]  = 1'b0;
        #1;
        checks++; if (req_ready !== 3'b001) begin errors++; $display("FAIL lock_exit_ready got %b exp 001", req_ready); end
    endtask

    task automatic test_lock_release_idle();
        do_reset();
        set_req(0, 1'b1, 1'b1, 5'd5, 32'h5);
        tick();
        set_req(0, 1'b0, 1'b0, 5'd5, 32'h5);
        set_req(1, 1'b1, 1'b0, 5'd6, 32'h6);
        #1;
        checks++; if (req_ready !== 3'b000) begin errors++; $display("FAIL idle_release_ready0 got %b exp 000", req_ready); end
        tick();
        checks++; if (req_ready !== 3'b010) begin errors++; $display("FAIL idle_release_ready1 got %b exp 010", req_ready); end
    endtask

    task automatic test_zero_drop();
        do_reset();
        set_req(1, 1'b1, 1'b0, 5'd0, 32'hDEAD_BEEF);
        #1;
        checks++; if (req_ready !== 3'b010) begin errors++; $display("FAIL zero_ready got %b exp 010", req_ready); end
        checks++; if (pending_mask !== 32'd0) begin errors++; $display("FAIL zero_pending got %h exp 0", pending_mask); end
        tick();
        req_valid = '0;
        #1;
        checks++; if (rf_we !== 1'b0 || drop_zero !== 1'b1 || grant_id !== 2'd1) begin
            errors++; $display("FAIL zero_out got we=%b dz=%b gid=%0d exp we=0 dz=1 gid=1", rf_we, drop_zero, grant_id);
        end
        tick();
        checks++; if (drop_zero !== 1'b0 || rf_we !== 1'b0) begin errors++; $display("FAIL zero_pulse got dz=%b we=%b exp 0 0", drop_zero, rf_we); end
    endtask

    task automatic test_hazard();
        do_reset();
        set_req(0, 1'b1, 1'b0, 5'd7, 32'h77);
        set_req(1, 1'b1, 1'b0, 5'd9, 32'h99);
        #1;
        checks++; if (pending_mask !== 32'h0000_0280) begin errors++; $display("FAIL hz_both got %h exp 00000280", pending_mask); end
        tick();
        req_valid[0] = 1'b0;
        #1;
        checks++; if (pending_mask !== 32'h0000_0280) begin errors++; $display("FAIL hz_inflight got %h exp 00000280", pending_mask); end
        tick();
        req_valid[1] = 1'b0;
        #1;
        checks++; if (pending_mask !== 32'h0000_0200) begin errors++; $display("FAIL hz_clear7 got %h exp 00000200", pending_mask); end
        tick();
        checks++; if (pending_mask !== 32'd0) begin errors++; $display("FAIL hz_empty got %h exp 0", pending_mask); end
    endtask

    task automatic test_reset_mid_lock();
        do_reset();
        set_req(1, 1'b1, 1'b1, 5'd4, 32'h44);
        tick();
        checks++; if (rf_we !== 1'b1) begin errors++; $display("FAIL ml_we_before got %b exp 1", rf_we); end
        rst = 1'b0;
        #1;
        checks++; if (rf_we !== 1'b0 || req_ready !== 3'b000) begin
            errors++; $display("FAIL ml_async got we=%b ready=%b exp 0 000", rf_we, req_ready);
        end
        set_req(0, 1'b1, 1'b0, 5'd1, 32'h1);
        set_req(1, 1'b1, 1'b0, 5'd2, 32'h2);
        set_req(2, 1'b1, 1'b0, 5'd3, 32'h3);
        #1;
        rst = 1'b1;
        #1;
        checks++; if (req_ready !== 3'b001) begin errors++; $display("FAIL ml_after got %b exp 001", req_ready); end
    endtask

    initial begin
        rst       = 1'b0;
        req_valid = '0;
        req_lock  = '0;
        req_addr  = '0;
        req_data  = '0;
        test_reset();
        test_round_robin();
        test_lock();
        test_lock_release_idle();
        test_zero_drop();
        test_hazard();
        test_reset_mid_lock();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
